// File: rtl/elbeth_dmem_responder.sv
// elbeth_dmem_responder: word-array data-memory responder with wait states, lane steering, range/size checks.
// Define ELBETH_DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them down.
module elbeth_dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_enb,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_data_size,
    input  logic [31:0] dmem_w_data,
    output logic [31:0] dmem_r_data,
    output logic        dmem_ready,
    output logic        dmem_error
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        we_q;
    logic [3:0]  size_q;
    logic [31:0] addr_q, w_data_q;
    logic        idle, cur_we, out_of_range, bad_size, misalign, err, commit, err_q;
    logic [3:0]  cur_size, lane_mask;
    logic [31:0] cur_addr, cur_w_data, cur_off, rd_word, shifted, ld_data, st_data, r_data_q;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];
    // With zero wait states the request commits on its accepting edge, so IDLE uses the live inputs.
    assign idle       = state == IDLE;
    assign cur_we     = idle ? dmem_we        : we_q;
    assign cur_size   = idle ? dmem_data_size : size_q;
    assign cur_addr   = idle ? dmem_addr      : addr_q;
    assign cur_w_data = idle ? dmem_w_data    : w_data_q;
    assign cur_off      = cur_addr - BASE_ADDR;
    assign out_of_range = (cur_addr < BASE_ADDR) || (cur_off >= LIMIT);
    assign bad_size     = !(cur_size == 4'b0001 || cur_size == 4'b0011 || cur_size == 4'b1111);
`ifdef ELBETH_DMEM_MISALIGN_TRAP_EN
    assign misalign = (cur_size == 4'b0011 && cur_off[0]) || (cur_size == 4'b1111 && cur_off[1:0] != 2'b00);
    assign lane     = cur_off[1:0];
`else
    assign misalign = 1'b0;
    assign lane     = cur_size == 4'b1111 ? 2'b00 : cur_size == 4'b0011 ? {cur_off[1], 1'b0} : cur_off[1:0];
`endif
    assign err       = out_of_range || bad_size || misalign;
    assign idx       = cur_off[AW+1:2];
    assign rd_word   = mem[idx];
    assign shifted   = rd_word >> {lane, 3'b000};
    assign ld_data   = cur_size == 4'b0001 ? (shifted & 32'h0000_00FF) :
                       cur_size == 4'b0011 ? (shifted & 32'h0000_FFFF) : shifted;
    assign st_data   = cur_size == 4'b0001 ? {4{cur_w_data[7:0]}} :
                       cur_size == 4'b0011 ? {2{cur_w_data[15:0]}} : cur_w_data;
    assign lane_mask = cur_size == 4'b0001 ? (4'b0001 << lane) :
                       cur_size == 4'b0011 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign commit    = state_nx == RESP && state != RESP;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (dmem_enb) begin
                state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
                cnt_nx   = 4'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                state_nx = !dmem_enb ? IDLE : cnt == 4'd0 ? RESP : WAIT;
                cnt_nx   = (dmem_enb && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            end
            default: state_nx = IDLE;
        endcase
    end
    // The array shares the reset block so a reset landing on the commit edge suppresses the write; it is never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 4'd0;
            addr_q   <= 32'd0;
            w_data_q <= 32'd0;
            err_q    <= 1'b0;
            r_data_q <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (idle && dmem_enb) begin
                we_q     <= dmem_we;
                size_q   <= dmem_data_size;
                addr_q   <= dmem_addr;
                w_data_q <= dmem_w_data;
            end
            if (commit) begin
                err_q    <= err;
                r_data_q <= (err || cur_we) ? 32'd0 : ld_data;
                for (int k = 0; k < 4; k++)
                    if (cur_we && !err && lane_mask[k]) mem[idx][8*k +: 8] <= st_data[8*k +: 8];
            end
        end
    end
    assign dmem_ready  = state == RESP;
    assign dmem_error  = dmem_ready && err_q;
    assign dmem_r_data = r_data_q;
endmodule

// File: tb/tb_elbeth_dmem_responder.sv
// tb_elbeth_dmem_responder: directed plus randomized accesses checked against a byte-array reference model.
module tb_elbeth_dmem_responder;
    localparam int          W     = 3;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dmem_enb = 1'b0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_data_size = '0;
    logic [31:0] dmem_w_data = '0;
    logic [31:0] dmem_r_data;
    logic        dmem_ready;
    logic        dmem_error;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] bmem [DEPTH*4];
    elbeth_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .dmem_enb(dmem_enb), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_data_size(dmem_data_size), .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data),
        .dmem_ready(dmem_ready), .dmem_error(dmem_error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic xact(input logic we, input logic [31:0] a, input logic [3:0] sz, input logic [31:0] wd, input string tag);
        logic e;
        logic [31:0] off, ea, exp_r;
        int n, k;
        off = a - BASE;
        e = !(sz == 4'h1 || sz == 4'h3 || sz == 4'hF) || a < BASE || off >= 32'(DEPTH * 4);
`ifdef ELBETH_DMEM_MISALIGN_TRAP_EN
        if ((sz == 4'h3 && a[0]) || (sz == 4'hF && a[1:0] != 2'b00)) e = 1'b1;
`endif
        ea = sz == 4'h3 ? (off & ~32'd1) : sz == 4'hF ? (off & ~32'd3) : off;
        n = sz == 4'h1 ? 1 : sz == 4'h3 ? 2 : 4;
        exp_r = '0;
        if (!e)
            for (int i = 0; i < n; i++)
                if (we) bmem[ea + 32'(i)] = wd[8*i +: 8];
                else exp_r[8*i +: 8] = bmem[ea + 32'(i)];
        @(negedge clk);
        dmem_enb = 1'b1; dmem_we = we; dmem_addr = a; dmem_data_size = sz; dmem_w_data = wd;
        for (k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (dmem_ready) break;
        end
        chk({tag, " latency"}, 32'(k), 32'(W + 1));
        chk({tag, " error"}, 32'(dmem_error), 32'(e));
        if (!we || e) chk({tag, " r_data"}, dmem_r_data, exp_r);
        dmem_enb = 1'b0;
        @(negedge clk);
        chk({tag, " ready_drop"}, 32'(dmem_ready), 32'd0);
        chk({tag, " error_drop"}, 32'(dmem_error), 32'd0);
        if (!we || e) chk({tag, " r_data_hold"}, dmem_r_data, exp_r);
    endtask
    initial begin
        int hits;
        logic [3:0] sz;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(dmem_ready), 32'd0);
        chk("reset error", 32'(dmem_error), 32'd0);
        chk("reset r_data", dmem_r_data, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) xact(1'b1, 32'(4 * i), 4'hF, $urandom, "init");
        xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "st_word");
        xact(1'b1, 32'h12, 4'h1, 32'h0000005A, "st_byte");
        xact(0, 32'h10, 4'hF, 0, "ld_word");
        chk("ld_word const", dmem_r_data, 32'hDE5ABEEF);
        xact(0, 32'h13, 4'h1, 0, "ld_byte");
        chk("ld_byte const", dmem_r_data, 32'h000000DE);
        xact(0, 32'h12, 4'h3, 0, "ld_half");
        chk("ld_half const", dmem_r_data, 32'h0000DE5A);
        xact(1'b1, 32'h0, 4'hF, 32'h0BADF00D, "st_w0");
        xact(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, "oor_st");
        xact(0, 32'h0, 4'hF, 0, "ld_w0");
        xact(0, 32'hFFFF_FFFC, 4'hF, 0, "oor_ld_high");
        xact(1'b1, 32'h10, 4'b0111, 32'h12345678, "bad_size_st");
        xact(0, 32'h10, 4'b0010, 0, "bad_size_ld");
        xact(0, 32'h10, 4'hF, 0, "ld_after_bad");
        xact(0, 32'h11, 4'h3, 0, "mis_half_ld");
        xact(0, 32'h13, 4'hF, 0, "mis_word_ld");
        xact(1'b1, 32'h15, 4'hF, 32'hA5A5C3C3, "mis_word_st");
        xact(1'b1, 32'h1B, 4'h3, 32'h00007E81, "mis_half_st");
        xact(0, 32'h14, 4'hF, 0, "ld_after_mis");
        xact(0, 32'h18, 4'hF, 0, "ld_after_mis_h");
        for (int i = 0; i < 80; i++) begin
            hits = int'($urandom_range(0, 15));
            sz = hits < 5 ? 4'h1 : hits < 10 ? 4'h3 : hits < 14 ? 4'hF : 4'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 127));
            xact(1'($urandom), a, sz, $urandom, "rand");
        end
        @(negedge clk);
        dmem_enb = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h20; dmem_data_size = 4'hF; dmem_w_data = 32'h11111111;
        hits = 0;
        repeat (2) begin @(negedge clk); if (dmem_ready) hits++; end
        dmem_enb = 1'b0;
        repeat (6) begin @(negedge clk); if (dmem_ready) hits++; end
        chk("abort ready", 32'(hits), 32'd0);
        xact(0, 32'h20, 4'hF, 0, "abort_ld");
        @(negedge clk);
        dmem_enb = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h20; dmem_data_size = 4'hF; dmem_w_data = 32'h11111111;
        hits = 0;
        repeat (2) begin @(negedge clk); if (dmem_ready) hits++; end
        rst = 1'b0;
        dmem_enb = 1'b0;
        @(negedge clk);
        chk("midrst r_data", dmem_r_data, 32'd0);
        chk("midrst error", 32'(dmem_error), 32'd0);
        rst = 1'b1;
        repeat (5) begin @(negedge clk); if (dmem_ready) hits++; end
        chk("midrst ready", 32'(hits), 32'd0);
        xact(0, 32'h20, 4'hF, 0, "midrst_ld");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
